// File: rtl/dlx_pipe_ctrl_if.sv
// ID-stage control bundle and pipeline status returned by dlx_pipe_ctrl.
// The master modport drives ID fields; the slave modport is the controller.
interface dlx_pipe_ctrl_if #(
    parameter int REG_AW = 5
);
    logic              IdValid;
    logic [REG_AW-1:0] IdRs1;
    logic [REG_AW-1:0] IdRs2;
    logic              IdUseRs2;
    logic              IdFPSrc;
    logic [REG_AW-1:0] IdDest;
    logic              IdRegWE;
    logic              IdFPDest;
    logic              IdMemRead;
    logic              IdMulti;
    logic              IdDiv;
    logic              BranchTaken;

    logic              Stall;
    logic              FlushIF;
    logic              ExValid;
    logic              MemValid;
    logic              WbValid;
    logic              WbRegWE;
    logic              WbFPDest;
    logic [REG_AW-1:0] WbDest;
    logic [1:0]        ExFwdA;
    logic [1:0]        ExFwdB;
    logic              FpuBusy;

    modport master (
        output IdValid, IdRs1, IdRs2, IdUseRs2, IdFPSrc, IdDest, IdRegWE,
               IdFPDest, IdMemRead, IdMulti, IdDiv, BranchTaken,
        input  Stall, FlushIF, ExValid, MemValid, WbValid, WbRegWE,
               WbFPDest, WbDest, ExFwdA, ExFwdB, FpuBusy
    );

    modport slave (
        input  IdValid, IdRs1, IdRs2, IdUseRs2, IdFPSrc, IdDest, IdRegWE,
               IdFPDest, IdMemRead, IdMulti, IdDiv, BranchTaken,
        output Stall, FlushIF, ExValid, MemValid, WbValid, WbRegWE,
               WbFPDest, WbDest, ExFwdA, ExFwdB, FpuBusy
    );
endinterface

// File: rtl/dlx_pipe_ctrl.sv
// DLX pipeline control: EX/MEM/WB control registers, load-use and FPU stalls,
// taken-branch flush and EX-stage forwarding selects for separate GPR/FPR files.
module dlx_pipe_ctrl #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    dlx_pipe_ctrl_if.slave    bus
);

    typedef enum logic [0:0] {
        FPU_IDLE = 1'b0,
        FPU_BUSY = 1'b1
    } fpu_state_e;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              fpdest;
        logic              regwe;
        logic              memread;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              users2;
        logic              fpsrc;
    } ex_stage_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              fpdest;
        logic              regwe;
        logic              memread;
    } mem_stage_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              fpdest;
        logic              regwe;
    } wb_stage_t;

    localparam ex_stage_t  EX_NOP  = {$bits(ex_stage_t){1'b0}};
    localparam mem_stage_t MEM_NOP = {$bits(mem_stage_t){1'b0}};
    localparam wb_stage_t  WB_NOP  = {$bits(wb_stage_t){1'b0}};
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    // R0 of the GPR file is hard-wired zero: it is never written nor forwarded
    function automatic logic wr_eff(input logic valid, input logic regwe,
                                    input logic fpdest, input logic [REG_AW-1:0] dest);
        return valid & regwe & (fpdest | (dest != {REG_AW{1'b0}}));
    endfunction

    function automatic logic hz_match(input logic wr, input logic [REG_AW-1:0] dest,
                                      input logic fpdest, input logic [REG_AW-1:0] idx,
                                      input logic fp);
        return wr & (dest == idx) & (fpdest == fp);
    endfunction

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q;
    fpu_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_wr_s, mem_wr_s, wb_wr_s;
    logic fpu_hold_s, load_use_s, enter_multi_s;
    logic stall_s, flush_s;
    logic [1:0] fwd_a_s, fwd_b_s;

    assign ex_wr_s  = wr_eff(ex_q.valid, ex_q.regwe, ex_q.fpdest, ex_q.dest);
    assign mem_wr_s = wr_eff(mem_q.valid, mem_q.regwe, mem_q.fpdest, mem_q.dest);
    assign wb_wr_s  = wr_eff(wb_q.valid, wb_q.regwe, wb_q.fpdest, wb_q.dest);

    assign fpu_hold_s = (state_q == FPU_BUSY) && (cnt_q != {CNT_W{1'b0}});
    assign load_use_s = bus.IdValid & ex_q.memread &
                        (hz_match(ex_wr_s, ex_q.dest, ex_q.fpdest, bus.IdRs1, bus.IdFPSrc) |
                         (bus.IdUseRs2 &
                          hz_match(ex_wr_s, ex_q.dest, ex_q.fpdest, bus.IdRs2, bus.IdFPSrc)));
    assign enter_multi_s = ~fpu_hold_s & ~bus.BranchTaken & ~load_use_s &
                           bus.IdValid & bus.IdMulti;

    // Pipeline advance: FPU hold beats branch flush, which beats load-use stall
    always_comb begin
        ex_d    = ex_q;
        mem_d   = MEM_NOP;
        stall_s = 1'b0;
        flush_s = 1'b0;
        if (fpu_hold_s) begin
            stall_s = 1'b1;
        end else begin
            mem_d = '{valid: ex_q.valid, dest: ex_q.dest, fpdest: ex_q.fpdest,
                      regwe: ex_q.regwe, memread: ex_q.memread};
            if (bus.BranchTaken) begin
                flush_s = 1'b1;
                ex_d    = EX_NOP;
            end else if (load_use_s) begin
                stall_s = 1'b1;
                ex_d    = EX_NOP;
            end else begin
                ex_d = '{valid: bus.IdValid, dest: bus.IdDest, fpdest: bus.IdFPDest,
                         regwe: bus.IdRegWE, memread: bus.IdMemRead, rs1: bus.IdRs1,
                         rs2: bus.IdRs2, users2: bus.IdUseRs2, fpsrc: bus.IdFPSrc};
            end
        end
    end

    // FPU next-state: counter holds remaining stall cycles of the op sitting in EX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FPU_IDLE: begin
                if (enter_multi_s) begin
                    state_d = FPU_BUSY;
                    cnt_d   = bus.IdDiv ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_d = FPU_IDLE;
                end
            end
            FPU_BUSY: begin
                if (fpu_hold_s) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (enter_multi_s) begin
                    cnt_d = bus.IdDiv ? DIV_LOAD : MUL_LOAD;
                end else begin
                    state_d = FPU_IDLE;
                end
            end
            default: begin
                state_d = FPU_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Forwarding selects: MEM wins over WB; a load still in MEM cannot forward
    always_comb begin
        fwd_a_s = 2'b00;
        fwd_b_s = 2'b00;
        if (ex_q.valid) begin
            if (hz_match(mem_wr_s, mem_q.dest, mem_q.fpdest, ex_q.rs1, ex_q.fpsrc) &&
                !mem_q.memread) begin
                fwd_a_s = 2'b01;
            end else if (hz_match(wb_wr_s, wb_q.dest, wb_q.fpdest, ex_q.rs1, ex_q.fpsrc)) begin
                fwd_a_s = 2'b10;
            end else begin
                fwd_a_s = 2'b00;
            end
            if (!ex_q.users2) begin
                fwd_b_s = 2'b00;
            end else if (hz_match(mem_wr_s, mem_q.dest, mem_q.fpdest, ex_q.rs2, ex_q.fpsrc) &&
                         !mem_q.memread) begin
                fwd_b_s = 2'b01;
            end else if (hz_match(wb_wr_s, wb_q.dest, wb_q.fpdest, ex_q.rs2, ex_q.fpsrc)) begin
                fwd_b_s = 2'b10;
            end else begin
                fwd_b_s = 2'b00;
            end
        end else begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end
    end

    // Stage and FSM registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ex_q    <= EX_NOP;
            mem_q   <= MEM_NOP;
            wb_q    <= WB_NOP;
            state_q <= FPU_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= '{valid: mem_q.valid, dest: mem_q.dest, fpdest: mem_q.fpdest,
                         regwe: mem_q.regwe};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Stall    = stall_s;
    assign bus.FlushIF  = flush_s;
    assign bus.ExValid  = ex_q.valid;
    assign bus.MemValid = mem_q.valid;
    assign bus.WbValid  = wb_q.valid;
    assign bus.WbRegWE  = wb_wr_s;
    assign bus.WbFPDest = wb_q.fpdest;
    assign bus.WbDest   = wb_q.dest;
    assign bus.ExFwdA   = fwd_a_s;
    assign bus.ExFwdB   = fwd_b_s;
    assign bus.FpuBusy  = fpu_hold_s;

endmodule
